// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment page controller.
package seg_pkg;

    localparam int unsigned PAGE_W  = 3;
    localparam int unsigned NUM_SRC = 4;
    localparam int unsigned DIGITS  = 4;
    localparam int unsigned NIB_W   = 4;
    localparam int unsigned HALF_W  = DIGITS * NIB_W;

    // page[2:1] picks the source, page[0] picks the 16-bit half
    localparam int unsigned PAGE_HALF_BIT = 0;
    localparam int unsigned PAGE_SRC_LSB  = 1;
    localparam int unsigned PAGE_SRC_MSB  = 2;

    typedef logic [NIB_W-1:0] nibble_t;

    function automatic nibble_t nib_of(input logic [HALF_W-1:0] half, input int unsigned idx);
        return half[idx*NIB_W +: NIB_W];
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter and a
// one-cycle pulse on each accepted rising level.
module btn_debounce #(
    parameter int unsigned DEB_CYCLES = 1000000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    output logic rise_o
);

    localparam int unsigned CNT_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync_q, s_q;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done;

    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        done    = (s_q != level_q) && (cnt_q == CNT_LAST);
        if (s_q != level_q) begin
            if (done) begin
                level_d = s_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Pulse is combinational so it coincides with the acceptance edge.
    assign rise_o = done & s_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= 1'b0;
            s_q     <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= raw_i;
            s_q     <= sync_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/seg_page_ctrl.sv
// Pages through 16-bit halves of four observation buses for the hex display.
// Define SEG_BLANK_LEADING_EN to request blanking of leading zero digits.
module seg_page_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 1000000,
    parameter int unsigned SRC_W      = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              btn_next_raw,
    input  logic              btn_hold_raw,
    input  logic [SRC_W-1:0]  src0,
    input  logic [SRC_W-1:0]  src1,
    input  logic [SRC_W-1:0]  src2,
    input  logic [SRC_W-1:0]  src3,
    output nibble_t           hex0,
    output nibble_t           hex1,
    output nibble_t           hex2,
    output nibble_t           hex3,
    output logic [PAGE_W-1:0] page,
    output logic              frozen,
    output logic [DIGITS-1:0] blank
);

    logic next_pulse, hold_pulse;

    logic [PAGE_W-1:0]               page_q;
    logic                            frozen_q;
    logic [NUM_SRC-1:0][SRC_W-1:0]   snap_q;
    logic [HALF_W-1:0]               hex_q;
    logic [HALF_W-1:0]               half;
    logic [PAGE_SRC_MSB:PAGE_SRC_LSB] sel;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_next_deb (
        .clk_i  (clock),
        .rst_ni (reset),
        .raw_i  (btn_next_raw),
        .rise_o (next_pulse)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_hold_deb (
        .clk_i  (clock),
        .rst_ni (reset),
        .raw_i  (btn_hold_raw),
        .rise_o (hold_pulse)
    );

    always_comb begin
        sel  = page_q[PAGE_SRC_MSB:PAGE_SRC_LSB];
        half = page_q[PAGE_HALF_BIT] ? snap_q[sel][HALF_W +: HALF_W]
                                     : snap_q[sel][0 +: HALF_W];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            page_q   <= '0;
            frozen_q <= 1'b0;
            snap_q   <= '0;
            hex_q    <= '0;
        end else begin
            if (next_pulse) begin
                page_q <= page_q + 1'b1;
            end
            frozen_q <= frozen_q ^ hold_pulse;
            // The freezing pulse cycle itself does not load, keeping the prior sample.
            if (!frozen_q && !hold_pulse) begin
                snap_q <= {src3, src2, src1, src0};
            end
            hex_q <= half;
        end
    end

`ifdef SEG_BLANK_LEADING_EN
    logic [DIGITS-1:0] blank_q, blank_d;

    always_comb begin
        blank_d    = '0;
        blank_d[3] = (nib_of(half, 3) == '0);
        blank_d[2] = blank_d[3] && (nib_of(half, 2) == '0);
        blank_d[1] = blank_d[2] && (nib_of(half, 1) == '0);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            blank_q <= '0;
        end else begin
            blank_q <= blank_d;
        end
    end

    assign blank = blank_q;
`else
    assign blank = '0;
`endif

    assign hex0   = nib_of(hex_q, 0);
    assign hex1   = nib_of(hex_q, 1);
    assign hex2   = nib_of(hex_q, 2);
    assign hex3   = nib_of(hex_q, 3);
    assign page   = page_q;
    assign frozen = frozen_q;

endmodule

// File: doc/seg_page_ctrl.md
Name: seg_page_ctrl

Overview:
- Feeds the four-digit seven-segment driver.
- Selects one 16-bit half of one of four 32-bit CPU observation buses (e.g. PC, instruction, ALU result, memory data) and presents it as four hex nibbles.
- Two raw push-buttons are debounced: one steps through the 8 display pages, the other freezes and unfreezes a snapshot of all sources.
- Outputs are registered, so the downstream multiplexer sees glitch-free nibbles.

Parameters:
- DEB_CYCLES, 1000000, stable-input cycles required before a button level is accepted (10 ms at 100 MHz); must be ≥ 2.
- SRC_W, 32, width of each source bus; fixed at 32, present for documentation and assertions only.

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- btn_next_raw  input  1  raw page-step button, active-high, asynchronous to clock.
- btn_hold_raw  input  1  raw freeze-toggle button, active-high, asynchronous to clock.
- src0  input  32  source 0.
- src1  input  32  source 1.
- src2  input  32  source 2.
- src3  input  32  source 3.
- hex0  output  4  rightmost digit (bits [3:0] of the selected half).
- hex1  output  4  bits [7:4] of the selected half.
- hex2  output  4  bits [11:8] of the selected half.
- hex3  output  4  leftmost digit (bits [15:12] of the selected half).
- page  output  3  current page; [2:1] = source index, [0] = half (0 = low, 1 = high).
- frozen  output  1  1 while the snapshot is held.
- blank  output  4  per-digit blank request; bit i corresponds to hexi.

Behaviour:
- Reset (reset = 0, asynchronous):
  - page = 0, frozen = 0, hex0..hex3 = 0, blank = 0.
  - Snapshot registers, debouncer state and sync flops are all 0.
- Debounce, per button:
  - 2-flop synchroniser produces s.
  - Counter restarts at 0 whenever s equals the accepted level.
  - While s differs from the accepted level, the counter increments each cycle. When it reaches DEB_CYCLES-1, the accepted level takes s and the counter clears.
  - A one-cycle pulse fires on an accepted 0→1 transition only.
  - Latency from a clean raw rising edge to the pulse: 2 (sync) + DEB_CYCLES cycles.
  - A bounce shorter than DEB_CYCLES produces no pulse.
- Page counter:
  - A next pulse sets page <= page + 1, with 7 wrapping to 0.
  - No other source changes page.
- Freeze:
  - A hold pulse toggles frozen.
  - Snapshot snap0..snap3 loads src0..src3 every cycle in which frozen = 0 and no hold pulse is asserted.
  - On the cycle a hold pulse sets frozen, the snapshot does not load; it keeps the previous cycle's values, i.e. src sampled on the cycle before the pulse.
  - While frozen, the snapshot is constant; paging still works and displays the frozen values.
  - Unfreezing resumes loading on the following cycle.
- Output:
  - hex0..hex3 are registered from snap[page[2:1]] half page[0].
  - Latency from snapshot change or page change to hex outputs: 1 cycle.
- Simultaneous next and hold pulses in one cycle: both act (page increments and frozen toggles).
- Sources are sampled directly and are assumed synchronous to clock.

Optional Feature:
- SEG_BLANK_LEADING_EN defined:
  - blank[3] = 1 if hex3 == 0.
  - blank[2] = 1 if hex3 == 0 and hex2 == 0.
  - blank[1] = 1 if hex3..hex1 are all 0.
  - blank[0] is always 0, so the value 0 shows a single "0".
  - blank is registered together with hex0..hex3 (same latency).
- Not defined: blank is tied to 4'b0000.

Decomposition:
- Shared package seg_pkg holds:
  - PAGE_W = 3, NUM_SRC = 4, DIGITS = 4.
  - A typedef for the 4-bit nibble.
  - The page-field slice positions.
- One sub-module, btn_debounce (synchroniser + counter + rising-edge pulse, parameter DEB_CYCLES), instantiated twice.

Test Plan (DEB_CYCLES = 4 in simulation):
- Reset with src0 = 32'h1234ABCD held → hex3..hex0 = 0 during reset; 1 cycle after loading completes, page 0 shows hex3..hex0 = A,B,C,D; frozen = 0.
- Clean next press held for 10 cycles → page goes 0→1 exactly 6 cycles after the raw edge; hex shows 1,2,3,4.
- Next-button bounce 1,0,1,0 at 1-cycle spacing, then held → exactly one page increment; 8 total presses return page to 0 (wrap).
- Freeze with src1 = 32'hDEADBEEF, then change src1 to 0 and step to page 3 → hex shows D,E,A,D; unfreeze → hex shows 0,0,0,0 within 2 cycles.
- Next and hold raw edges aligned → page increments and frozen toggles in the same cycle.
- SEG_BLANK_LEADING_EN with selected half 16'h0050 → blank = 4'b1100; with half 16'h0000 → blank = 4'b1110; macro undefined → blank = 4'b0000.
- Assert reset mid-debounce and while frozen → all outputs 0 immediately; no pulse after release until a fresh full debounce interval.
